// File: rtl/key_filter.sv
// key_filter
//   Debounces KEY_W raw active-low pushbuttons. Each key is synchronized,
//   qualified by an independent debounce FSM and turned into a single-cycle
//   pulse per accepted press. A debounced level is also exported.
//
// Ports
//   clk                in            system clock
//   rst_n              in            asynchronous active-low reset
//   keys_n             in  [KEY_W]   raw keys, 0 = pressed, async to clk
//   neg_keys_filtered  out [KEY_W]   one-cycle pulse per accepted press
//   keys_level         out [KEY_W]   1 while key is debounced-pressed

module key_filter_lane #(
    parameter int N  = 1000000,
    parameter int CW = $clog2(N)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pulse,
    output logic level
);

    typedef enum logic [2:0] {
        LOCKOUT,
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [1:0]    sync_q;
    logic          s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_d;

    // Sync flops reset to "released" so a key held through reset still
    // looks released for two cycles; LOCKOUT then catches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], key_n};
    end

    assign s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            // Must see N consecutive released samples before arming.
            LOCKOUT: begin
                if (!s)                 cnt_d = '0;
                else if (cnt_q == LAST) state_d = IDLE;
                else                    cnt_d = cnt_q + CW'(1);
            end
            IDLE: begin
                if (!s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (s) state_d = IDLE;
                else if (cnt_q == LAST) begin
                    state_d = HELD;
                    pulse_d = 1'b1;
                end
                else cnt_d = cnt_q + CW'(1);
            end
            HELD: begin
                if (s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back to pressed returns to HELD silently.
                if (!s)                 state_d = HELD;
                else if (cnt_q == LAST) state_d = IDLE;
                else                    cnt_d = cnt_q + CW'(1);
            end
            default: begin
                state_d = LOCKOUT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOCKOUT;
            cnt_q   <= '0;
            pulse   <= 1'b0;
            level   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse   <= pulse_d;
            level   <= (state_d == HELD) || (state_d == RELEASE_WAIT);
        end
    end

endmodule

module key_filter #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int KEY_W           = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] keys_n,
    output logic [KEY_W-1:0] neg_keys_filtered,
    output logic [KEY_W-1:0] keys_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    for (genvar g = 0; g < KEY_W; g++) begin : g_lane
        key_filter_lane #(
            .N  (DEBOUNCE_CYCLES),
            .CW (CW)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .key_n (keys_n[g]),
            .pulse (neg_keys_filtered[g]),
            .level (keys_level[g])
        );
    end

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter with DEBOUNCE_CYCLES = 8, KEY_W = 4.
// Expected pulses (cycle, value) are queued when a press is driven and
// consumed by a monitor whenever the DUT pulses.

module tb_key_filter;

    localparam int N = 8;
    localparam int W = 4;
    localparam int LAT = N + 3;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] keys_n;
    logic [W-1:0] neg_keys_filtered;
    logic [W-1:0] keys_level;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    key_filter #(.DEBOUNCE_CYCLES(N), .KEY_W(W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .keys_n            (keys_n),
        .neg_keys_filtered (neg_keys_filtered),
        .keys_level        (keys_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic [3:0] val, input logic [3:0] pulse_exp);
        @(negedge clk);
        keys_n = val;
        if (pulse_exp != 4'b0) sb.push_back('{cyc + LAT, pulse_exp});
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse monitor: every pulse must match the head of the scoreboard,
    // and an entry whose cycle has passed counts as a missing pulse.
    always @(negedge clk) begin
        if (sb.size() > 0 && cyc > sb[0].cyc) begin
            chk("pulse_missing", 0, int'(sb[0].val));
            void'(sb.pop_front());
        end
        if (rst_n && neg_keys_filtered != 4'b0) begin
            if (sb.size() == 0) begin
                chk("spurious_pulse", int'(neg_keys_filtered), 0);
            end else begin
                chk("pulse_cyc", cyc, sb[0].cyc);
                chk("pulse_val", int'(neg_keys_filtered), int'(sb[0].val));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        keys_n = 4'b1111;
        wait_cyc(3);
        chk("rst_pulse", int'(neg_keys_filtered), 0);
        chk("rst_level", int'(keys_level), 0);
        rst_n = 1'b1;
        wait_cyc(20);

        // 1. clean press of key 3
        drive(4'b0111, 4'b1000);
        wait_cyc(LAT - 1);
        chk("t1_level_before", int'(keys_level), 0);
        wait_cyc(1);
        chk("t1_level_after", int'(keys_level), 4'b1000);
        wait_cyc(100);
        chk("t1_level_held", int'(keys_level), 4'b1000);
        drive(4'b1111, 4'b0);
        wait_cyc(20);
        chk("t1_level_rel", int'(keys_level), 0);

        // 2. press bounce on key 0, then a clean hold
        for (int i = 0; i < 5; i++) begin
            drive(4'b1110, 4'b0);
            wait_cyc(2);
            drive(4'b1111, 4'b0);
            wait_cyc(2);
        end
        drive(4'b1110, 4'b0001);
        wait_cyc(20);
        chk("t2_level", int'(keys_level), 4'b0001);

        // 3. release bounce on key 0
        drive(4'b1111, 4'b0);
        wait_cyc(3);
        drive(4'b1110, 4'b0);
        wait_cyc(10);
        chk("t3_level_rebounce", int'(keys_level), 4'b0001);
        drive(4'b1111, 4'b0);
        wait_cyc(LAT - 1);
        chk("t3_level_before", int'(keys_level), 4'b0001);
        wait_cyc(1);
        chk("t3_level_after", int'(keys_level), 0);
        wait_cyc(10);
        drive(4'b1110, 4'b0001);
        wait_cyc(20);
        drive(4'b1111, 4'b0);
        wait_cyc(20);

        // 4. key 3 held through reset
        @(negedge clk);
        keys_n = 4'b0111;
        rst_n  = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(50);
        chk("t4_level_locked", int'(keys_level), 0);
        drive(4'b1111, 4'b0);
        wait_cyc(20);
        drive(4'b0111, 4'b1000);
        wait_cyc(20);
        chk("t4_level_pressed", int'(keys_level), 4'b1000);
        drive(4'b1111, 4'b0);
        wait_cyc(20);

        // 5. simultaneous press of keys 3 and 0
        drive(4'b0110, 4'b1001);
        wait_cyc(20);
        chk("t5_level", int'(keys_level), 4'b1001);
        drive(4'b1111, 4'b0);
        wait_cyc(20);

        // 6. reset while key 1 is in PRESS_WAIT with cnt = 5, key 2 held
        drive(4'b1011, 4'b0100);
        wait_cyc(20);
        drive(4'b1001, 4'b0);
        wait_cyc(8);
        chk("t6_level_pre", int'(keys_level), 4'b0100);
        rst_n = 1'b0;
        #1;
        chk("t6_async_pulse", int'(neg_keys_filtered), 0);
        chk("t6_async_level", int'(keys_level), 0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(40);
        chk("t6_level_locked", int'(keys_level), 0);
        drive(4'b1111, 4'b0);
        wait_cyc(20);
        drive(4'b1101, 4'b0010);
        wait_cyc(20);
        chk("t6_level_pressed", int'(keys_level), 4'b0010);
        drive(4'b1111, 4'b0);
        wait_cyc(20);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
